// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// AND/OR/ADD/SUB/SLT finish in one cycle, SLL/SRL shift one bit per cycle,
// and MUL runs a WIDTH-cycle radix-2 shift-add loop.
// Build option: define SEQ_ALU_MUL_EN to build the multiplier; without it,
// op 101 completes at once with z = 0 and ovf = 1 as an unsupported-op flag.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = SHW + 1;  // counter must hold WIDTH for MUL

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_sh;     // value being shifted, or multiplicand
  logic [CW-1:0]    r_cnt;    // remaining BUSY cycles
  logic [WIDTH-1:0] r_z;
  logic             r_zero;
  logic             r_ovf;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
`endif

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic [WIDTH-1:0] w_quick_z;
  logic             w_quick_ovf;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_last;

  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign out_valid  = (r_state == S_DONE);
  assign z          = r_z;
  assign zero       = r_zero;
  assign ovf        = r_ovf;

  assign w_accept   = in_valid && in_ready;
  assign w_shamt    = b[SHW-1:0];
  assign w_is_shift = (op == OP_SLL) || (op == OP_SRL);
  assign w_sum      = a + b;
  assign w_diff     = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_lt       = $signed(a) < $signed(b);

  assign w_shift_next = (r_op == OP_SLL) ? (r_sh << 1) : (r_sh >> 1);
  assign w_last       = (r_cnt == CW'(1));
`ifdef SEQ_ALU_MUL_EN
  assign w_acc_next   = r_acc + (r_mplier[0] ? r_sh : '0);
`endif

  // Single-cycle result and overflow flag for ops that skip BUSY
  always_comb begin
    w_quick_z   = '0;
    w_quick_ovf = 1'b0;
    case (op)
      OP_AND: w_quick_z = a & b;
      OP_OR:  w_quick_z = a | b;
      OP_ADD: begin
        w_quick_z   = w_sum;
        w_quick_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_quick_z   = w_diff;
        w_quick_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: w_quick_z = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLL, OP_SRL: w_quick_z = a;  // only reached with a zero shift amount
      default: begin
`ifdef SEQ_ALU_MUL_EN
        w_quick_ovf = 1'b0;
`else
        w_quick_ovf = 1'b1;           // MUL not built: flag it as unsupported
`endif
      end
    endcase
  end

  // Control FSM plus iterative shift / shift-add datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_AND;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_z      <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_mplier <= '0;
      r_acc    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= op;
            if (w_is_shift && (w_shamt != '0)) begin
              r_sh    <= a;
              r_cnt   <= {1'b0, w_shamt};
              r_state <= S_BUSY;
            end
`ifdef SEQ_ALU_MUL_EN
            else if (op == OP_MUL) begin
              r_sh     <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= CW'(WIDTH);
              r_state  <= S_BUSY;
            end
`endif
            else begin
              r_z     <= w_quick_z;
              r_zero  <= (w_quick_z == '0);
              r_ovf   <= w_quick_ovf;
              r_state <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
`ifdef SEQ_ALU_MUL_EN
          if (r_op == OP_MUL) begin
            r_acc    <= w_acc_next;
            r_sh     <= r_sh << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
              r_z     <= w_acc_next;
              r_zero  <= (w_acc_next == '0);
              r_ovf   <= 1'b0;
              r_state <= S_DONE;
            end
          end else
`endif
          begin
            r_sh <= w_shift_next;
            if (w_last) begin
              r_z     <= w_shift_next;
              r_zero  <= (w_shift_next == '0);
              r_ovf   <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
